controle_temporizador: RTL and testbench

//  Sequencer directly upstream of the 4-bit down counter (load/clear/enable, 74163-style active-low ctrl).

---
 rtl/controle_temporizador_pkg.sv | 30 +++
 rtl/controle_temporizador_if.sv | 47 ++++
 rtl/controle_temporizador_gerador_tick.sv | 48 ++++
 rtl/controle_temporizador.sv | 158 +++++++++++++++
 tb/tb_controle_temporizador.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/controle_temporizador_pkg.sv
// controle_temporizador_pkg
// Shared definitions for the round timer sequencer: state encoding, default
// widths and a helper that sizes the prescaler counter.
// No ports; imported by the interface, the prescaler and the top module.

package controle_temporizador_pkg;

    // Default counter data width; must match the external down counter.
    localparam int LARGURA_PADRAO  = 4;

    // Default number of clock cycles per counter decrement.
    localparam int PRESCALE_PADRAO = 1000;

    // Sequencer states. The numeric values are visible on db_estado, so
    // they are fixed explicitly rather than left to the tool.
    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        CARREGA  = 3'd1,
        CONTA    = 3'd2,
        PAUSA    = 3'd3,
        ESGOTADO = 3'd4
    } estado_t;

    // Width of the prescaler counter. A prescale of 1 still needs one bit
    // so the counter register never collapses to zero width.
    function automatic int largura_prescaler(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/controle_temporizador_if.sv
// controle_temporizador_if
// Control/data bundle between the sequencer and a 74163-style down counter.
// Ports (signals):
//   cnt_clr  active-low synchronous clear of the counter (clears to all ones)
//   cnt_ld   active-low synchronous load of cnt_d
//   cnt_ent  count enable T (also gates rco)
//   cnt_enp  count enable P
//   cnt_d    parallel load value
//   cnt_q    counter output
//   cnt_rco  ripple carry out: cnt_ent && cnt_q == 0
// Modports: master = sequencer side, slave = counter side.

interface controle_temporizador_if
    import controle_temporizador_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
);

    logic               cnt_clr;
    logic               cnt_ld;
    logic               cnt_ent;
    logic               cnt_enp;
    logic [LARGURA-1:0] cnt_d;
    logic [LARGURA-1:0] cnt_q;
    logic               cnt_rco;

    modport master (
        output cnt_clr,
        output cnt_ld,
        output cnt_ent,
        output cnt_enp,
        output cnt_d,
        input  cnt_q,
        input  cnt_rco
    );

    modport slave (
        input  cnt_clr,
        input  cnt_ld,
        input  cnt_ent,
        input  cnt_enp,
        input  cnt_d,
        output cnt_q,
        output cnt_rco
    );

endinterface

// File: rtl/controle_temporizador_gerador_tick.sv
// controle_temporizador_gerador_tick
// Prescaler for the round timer: counts 0..PRESCALE-1 while 'conta' is high
// and raises 'tick' during the last cycle of each period.
// Ports:
//   clock  in   system clock
//   clr    in   asynchronous active-low reset (count back to 0)
//   zera   in   synchronous clear of the count (has priority over conta)
//   conta  in   advance the count this cycle; when low the count is frozen
//   tick   out  conta && count == PRESCALE-1

module controle_temporizador_gerador_tick
    import controle_temporizador_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_PADRAO
)(
    input  logic clock,
    input  logic clr,
    input  logic zera,
    input  logic conta,
    output logic tick
);

    localparam int            PW     = largura_prescaler(PRESCALE);
    localparam logic [PW-1:0] ULTIMO = PW'(PRESCALE - 1);

    logic [PW-1:0] contagem;

    // Tick is only meaningful while counting, so it is gated by conta; a
    // frozen prescaler sitting on its last value must not keep ticking.
    assign tick = conta && (contagem == ULTIMO);

    // Period counter. Wrapping explicitly at ULTIMO keeps non-power-of-two
    // prescales exact.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta) begin
            if (contagem == ULTIMO) begin
                contagem <= '0;
            end else begin
                contagem <= contagem + 1'b1;
            end
        end
    end

endmodule

// File: rtl/controle_temporizador.sv
// controle_temporizador
// Sequencer sitting in front of a 4-bit 74163-style down counter. Loads a
// per-round limit, lets the counter decrement once per prescaled tick and
// pulses timeout when the count reaches zero.
// Ports:
//   clock      in   system clock, rising edge
//   clr        in   asynchronous active-low reset
//   iniciar    in   start/restart request (captures limite)
//   parar      in   abort request, highest priority
//   pausar     in   level, freezes the countdown while high
//   limite     in   initial count for the round
//   cnt        if   master side of the counter bundle (clr/ld/ent/enp/d, q/rco)
//   timeout    out  one-cycle pulse when the countdown expires
//   ativo      out  high while loading, counting or paused
//   restante   out  counter value while ativo, else 0
//   db_estado  out  current state encoding

module controle_temporizador
    import controle_temporizador_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_PADRAO,
    parameter int LARGURA  = LARGURA_PADRAO
)(
    input  logic                    clock,
    input  logic                    clr,
    input  logic                    iniciar,
    input  logic                    parar,
    input  logic                    pausar,
    input  logic [LARGURA-1:0]      limite,
    controle_temporizador_if.master cnt,
    output logic                    timeout,
    output logic                    ativo,
    output logic [LARGURA-1:0]      restante,
    output logic [2:0]              db_estado
);

    estado_t            estado;
    estado_t            proximo;
    logic               captura;
    logic [LARGURA-1:0] limite_reg;
    logic               tick;
    logic               zera_pre;
    logic               conta_pre;

    // The prescaler restarts at every load and only runs in CONTA, so a
    // pause resumes the period exactly where it stopped.
    assign zera_pre  = (estado == CARREGA);
    assign conta_pre = (estado == CONTA);

    controle_temporizador_gerador_tick #(
        .PRESCALE (PRESCALE)
    ) u_gerador_tick (
        .clock (clock),
        .clr   (clr),
        .zera  (zera_pre),
        .conta (conta_pre),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Limit captured on every accepted start so a restart mid-round picks
    // up the new value; the counter loads it one cycle later in CARREGA.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            limite_reg <= '0;
        end else if (captura) begin
            limite_reg <= limite;
        end
    end

    // Next-state logic. The per-state transitions are evaluated first and
    // then overridden by iniciar and finally by parar, which gives the
    // priority parar > iniciar > pausar/rco. Within CONTA an expired count
    // wins over a pause request so a round at zero always ends.
    always_comb begin
        proximo = estado;
        captura = 1'b0;

        case (estado)
            OCIOSO:   proximo = OCIOSO;
            CARREGA:  proximo = CONTA;
            CONTA: begin
                if (cnt.cnt_rco) begin
                    proximo = ESGOTADO;
                end else if (pausar) begin
                    proximo = PAUSA;
                end
            end
            PAUSA: begin
                if (!pausar) begin
                    proximo = CONTA;
                end
            end
            ESGOTADO: proximo = OCIOSO;
            default:  proximo = OCIOSO;
        endcase

        if (iniciar && (estado inside {OCIOSO, CARREGA, CONTA, PAUSA, ESGOTADO})) begin
            proximo = CARREGA;
            captura = 1'b1;
        end

        if (parar) begin
            proximo = OCIOSO;
            captura = 1'b0;
        end
    end

    // Counter control and status outputs. Everything is decoded from the
    // state except cnt_enp, which also needs the tick and rco: enabling P
    // only when rco is low stops the counter from wrapping past zero, and a
    // tick that coincides with rco is simply dropped.
    always_comb begin
        cnt.cnt_clr = 1'b1;
        cnt.cnt_ld  = 1'b1;
        cnt.cnt_ent = 1'b0;
        cnt.cnt_enp = 1'b0;
        timeout     = 1'b0;
        ativo       = 1'b0;

        case (estado)
            OCIOSO: begin
                cnt.cnt_clr = 1'b0;
            end
            CARREGA: begin
                cnt.cnt_ld = 1'b0;
                ativo      = 1'b1;
            end
            CONTA: begin
                cnt.cnt_ent = 1'b1;
                cnt.cnt_enp = tick && !cnt.cnt_rco;
                ativo       = 1'b1;
            end
            PAUSA: begin
                ativo = 1'b1;
            end
            ESGOTADO: begin
                timeout = 1'b1;
            end
            default: begin
                cnt.cnt_clr = 1'b1;
            end
        endcase
    end

    assign cnt.cnt_d = limite_reg;
    assign restante  = ativo ? cnt.cnt_q : '0;
    assign db_estado = estado;

endmodule

// File: tb/tb_controle_temporizador.sv
// tb_controle_temporizador
// Bench for the round timer sequencer driving a behavioural 74163-style down
// counter. A cycle-level model of the round (mode, remaining count, position
// in the prescale period) predicts every output each cycle; scripted rounds
// pin the model with hand-derived timeout cycles and counter values.

module tb_controle_temporizador;
    import controle_temporizador_pkg::*;

    localparam int PRESCALE = 4;
    localparam int LARGURA  = 4;

    // Model mode values equal the documented debug encoding.
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic               clock   = 1'b0;
    logic               clr     = 1'b0;
    logic               iniciar = 1'b0;
    logic               parar   = 1'b0;
    logic               pausar  = 1'b0;
    logic [LARGURA-1:0] limite  = '0;
    logic               timeout;
    logic               ativo;
    logic [LARGURA-1:0] restante;
    logic [2:0]         db_estado;

    int checks   = 0;
    int failures = 0;
    logic check_en = 1'b0;

    controle_temporizador_if #(.LARGURA(LARGURA)) cnt_bus ();

    controle_temporizador #(
        .PRESCALE (PRESCALE),
        .LARGURA  (LARGURA)
    ) dut (
        .clock     (clock),
        .clr       (clr),
        .iniciar   (iniciar),
        .parar     (parar),
        .pausar    (pausar),
        .limite    (limite),
        .cnt       (cnt_bus),
        .timeout   (timeout),
        .ativo     (ativo),
        .restante  (restante),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Behavioural down counter acting as the sequencer's load.
    logic [LARGURA-1:0] q_carga = '1;

    always @(posedge clock) begin
        if (!cnt_bus.cnt_clr) begin
            q_carga <= '1;
        end else if (!cnt_bus.cnt_ld) begin
            q_carga <= cnt_bus.cnt_d;
        end else if (cnt_bus.cnt_ent && cnt_bus.cnt_enp) begin
            q_carga <= q_carga - 1'b1;
        end
    end

    assign cnt_bus.cnt_q   = q_carga;
    assign cnt_bus.cnt_rco = cnt_bus.cnt_ent && (q_carga == '0);

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Round model: what the counter holds, where in the prescale period we
    // are and which phase of the round we are in.
    int                 m_mode = M_IDLE;
    int                 m_pre  = 0;
    logic [LARGURA-1:0] m_lim  = '0;
    logic [LARGURA-1:0] m_q    = '1;

    always @(posedge clock) begin : modelo
        logic at_zero;
        logic dec;
        if (!clr) begin
            m_mode = M_IDLE;
            m_pre  = 0;
            m_lim  = '0;
            m_q    = '1;
        end else begin
            at_zero = (m_mode == M_RUN) && (m_q == 0);
            dec     = (m_mode == M_RUN) && (m_pre == PRESCALE - 1) && !at_zero;

            if (m_mode == M_IDLE)      m_q = '1;
            else if (m_mode == M_LOAD) m_q = m_lim;
            else if (dec)              m_q = m_q - 1'b1;

            if (m_mode == M_LOAD)     m_pre = 0;
            else if (m_mode == M_RUN) m_pre = (m_pre + 1) % PRESCALE;

            if (parar) begin
                m_mode = M_IDLE;
            end else if (iniciar) begin
                m_lim  = limite;
                m_mode = M_LOAD;
            end else begin
                case (m_mode)
                    M_LOAD:  m_mode = M_RUN;
                    M_RUN:   m_mode = at_zero ? M_DONE : (pausar ? M_PAUSE : M_RUN);
                    M_PAUSE: m_mode = pausar ? M_PAUSE : M_RUN;
                    M_DONE:  m_mode = M_IDLE;
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin : comparador
        logic       e_ativo;
        logic       e_zero;
        logic       e_enp;
        logic [7:0] e_rest;
        if (check_en && clr) begin
            e_ativo = (m_mode == M_LOAD) || (m_mode == M_RUN) || (m_mode == M_PAUSE);
            e_zero  = (m_mode == M_RUN) && (m_q == 0);
            e_enp   = (m_mode == M_RUN) && (m_pre == PRESCALE - 1) && !e_zero;
            e_rest  = e_ativo ? 8'(m_q) : 8'd0;
            check_output("cnt_clr",   8'(cnt_bus.cnt_clr), (m_mode != M_IDLE) ? 8'd1 : 8'd0);
            check_output("cnt_ld",    8'(cnt_bus.cnt_ld),  (m_mode != M_LOAD) ? 8'd1 : 8'd0);
            check_output("cnt_ent",   8'(cnt_bus.cnt_ent), (m_mode == M_RUN)  ? 8'd1 : 8'd0);
            check_output("cnt_enp",   8'(cnt_bus.cnt_enp), 8'(e_enp));
            check_output("cnt_d",     8'(cnt_bus.cnt_d),   8'(m_lim));
            check_output("timeout",   8'(timeout),         (m_mode == M_DONE) ? 8'd1 : 8'd0);
            check_output("ativo",     8'(ativo),           8'(e_ativo));
            check_output("restante",  8'(restante),        e_rest);
            check_output("db_estado", 8'(db_estado),       8'(m_mode));
            check_output("cnt_q",     8'(q_carga),         8'(m_q));
        end
    end

    // Samples of the cycle's outputs taken just before its inputs change.
    logic               s_timeout;
    logic               s_ativo;
    logic               s_ld;
    logic               s_enp;
    logic [LARGURA-1:0] s_rest;
    logic [LARGURA-1:0] s_q;

    logic [LARGURA-1:0] tr_rest  [0:63];
    logic [LARGURA-1:0] tr_q     [0:63];
    logic               tr_ativo [0:63];
    logic               tr_ld    [0:63];
    int                 to_first;
    int                 to_count;
    logic               enp_seen;

    task automatic apply_stimulus(input logic ini, input logic par, input logic pau, input logic [LARGURA-1:0] lim);
        @(negedge clock);
        #1;
        s_timeout = timeout;
        s_ativo   = ativo;
        s_ld      = cnt_bus.cnt_ld;
        s_enp     = cnt_bus.cnt_enp;
        s_rest    = restante;
        s_q       = q_carga;
        iniciar   = ini;
        parar     = par;
        pausar    = pau;
        limite    = lim;
    endtask

    task automatic settle();
        apply_stimulus(1'b0, 1'b1, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    endtask

    // One scripted round. Cycle 0 carries iniciar with lim0; optional
    // second start, abort and pause window are given in cycle numbers.
    task automatic run_script(input logic [LARGURA-1:0] lim0, input int ncyc,
                              input int pau_from, input int pau_len, input int par_at,
                              input int ini_at, input logic [LARGURA-1:0] ini_lim);
        to_first = -1;
        to_count = 0;
        enp_seen = 1'b0;
        settle();
        for (int n = 0; n < ncyc; n++) begin
            logic               ini;
            logic [LARGURA-1:0] lim;
            ini = (n == 0) || (n == ini_at);
            lim = (n == ini_at) ? ini_lim : lim0;
            apply_stimulus(ini, (n == par_at), (n >= pau_from) && (n < pau_from + pau_len), lim);
            tr_rest[n]  = s_rest;
            tr_q[n]     = s_q;
            tr_ativo[n] = s_ativo;
            tr_ld[n]    = s_ld;
            if (s_timeout) begin
                if (to_first < 0) to_first = n;
                to_count++;
            end
            if (s_enp) enp_seen = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #1;
        iniciar = 1'b0;
        parar   = 1'b0;
        pausar  = 1'b0;
        clr     = 1'b0;
        #1;
        check_output("rst_async_ativo",   8'(ativo),           8'd0);
        check_output("rst_async_cnt_clr", 8'(cnt_bus.cnt_clr), 8'd0);
        check_output("rst_async_estado",  8'(db_estado),       8'd0);
        @(negedge clock);
        #1;
        check_output("rst_q_cleared",  8'(q_carga),  8'hF);
        check_output("rst_restante",   8'(restante), 8'd0);
        check_output("rst_timeout",    8'(timeout),  8'd0);
        clr = 1'b1;
    endtask

    initial begin
        logic pau_r;

        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check_output("reset_cnt_clr",  8'(cnt_bus.cnt_clr), 8'd0);
        check_output("reset_cnt_ld",   8'(cnt_bus.cnt_ld),  8'd1);
        check_output("reset_cnt_ent",  8'(cnt_bus.cnt_ent), 8'd0);
        check_output("reset_cnt_enp",  8'(cnt_bus.cnt_enp), 8'd0);
        check_output("reset_timeout",  8'(timeout),         8'd0);
        check_output("reset_ativo",    8'(ativo),           8'd0);
        check_output("reset_estado",   8'(db_estado),       8'd0);
        check_output("reset_cnt_d",    8'(cnt_bus.cnt_d),   8'd0);
        clr      = 1'b1;
        check_en = 1'b1;

        // limite=3: load in cycle 1, Q=3,2,1,0 every 4 cycles, timeout at 15.
        run_script(4'd3, 30, -1, 0, -1, -1, 4'd0);
        check_output("l3_ld_cycle1",   8'(tr_ld[1]),    8'd0);
        check_output("l3_q_cycle2",    8'(tr_rest[2]),  8'd3);
        check_output("l3_q_cycle6",    8'(tr_rest[6]),  8'd2);
        check_output("l3_q_cycle10",   8'(tr_rest[10]), 8'd1);
        check_output("l3_q_cycle14",   8'(tr_rest[14]), 8'd0);
        check_output("l3_timeout_at",  8'(to_first),    8'd15);
        check_output("l3_timeout_cnt", 8'(to_count),    8'd1);
        check_output("l3_ativo_after", 8'(tr_ativo[16]), 8'd0);

        // limite=0: immediate expiry, counter must not wrap.
        run_script(4'd0, 10, -1, 0, -1, -1, 4'd0);
        check_output("l0_timeout_at", 8'(to_first), 8'd3);
        check_output("l0_enp_never",  8'(enp_seen), 8'd0);
        check_output("l0_q_no_wrap",  8'(tr_q[3]),  8'd0);

        // limite=2 with a 10-cycle pause: timeout moves from 11 to 21.
        run_script(4'd2, 30, 5, 10, -1, -1, 4'd0);
        check_output("pause_timeout_at",  8'(to_first),   8'd21);
        check_output("pause_q_held",      8'(tr_rest[10]), 8'd1);

        // limite=5 aborted at cycle 8.
        run_script(4'd5, 30, -1, 0, 8, -1, 4'd0);
        check_output("abort_ativo_c9",  8'(tr_ativo[9]), 8'd0);
        check_output("abort_no_timeout", 8'(to_count),   8'd0);

        // iniciar and parar together: the abort wins.
        run_script(4'd5, 12, -1, 0, 0, -1, 4'd0);
        check_output("ini_par_ativo_c1", 8'(tr_ativo[1]), 8'd0);
        check_output("ini_par_no_to",    8'(to_count),    8'd0);

        // Restart at cycle 10 with limite=2: reload and timeout at 21.
        run_script(4'd5, 30, -1, 0, -1, 10, 4'd2);
        check_output("restart_q_c12",     8'(tr_rest[12]), 8'd2);
        check_output("restart_timeout",   8'(to_first),    8'd21);
        check_output("restart_to_count",  8'(to_count),    8'd1);

        // Reset in the middle of a count.
        settle();
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'd5);
        repeat (4) apply_stimulus(1'b0, 1'b0, 1'b0, 4'd5);
        pulse_reset();

        // Random traffic checked by the every-cycle comparator.
        pau_r = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset();
            end
            if ($urandom_range(0, 11) == 0) pau_r = ~pau_r;
            apply_stimulus(($urandom_range(0, 39) == 0),
                           ($urandom_range(0, 79) == 0),
                           pau_r,
                           4'($urandom_range(0, 15)));
        end

        settle();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
